// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, PC select
// codes, decoder field values and the WB-stage PC source selection.
package ctrl_defs;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_IMM = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  localparam logic [1:0] JUMP_JALR = 2'b11;
  localparam logic [1:0] RES_LINK  = 2'b10;

  // JALR outranks JAL, which outranks a taken conditional branch.
  function automatic logic [1:0] pc_select(input logic       branch,
                                           input logic [1:0] jump,
                                           input logic [1:0] result_sel,
                                           input logic       taken);
    if (jump == JUMP_JALR)         return PCSEL_ALU;
    else if (result_sel == RES_LINK) return PCSEL_IMM;
    else if (branch && taken)      return PCSEL_IMM;
    else                           return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_timeout.sv
// Wait-cycle counter shared by the instruction fetch and data access states;
// flags expiry on the last allowed cycle that still has no ready.
module mem_timeout #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ready in the final cycle is excluded here, so it wins over the timeout.
  assign expired = (MEM_TIMEOUT > 0) && enable && !ready && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !ready)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I core: FETCH, DECODE, EXEC,
// optional MEM and WB, with a sticky HALT on illegal instructions or bus timeout.
module multicycle_ctrl
  import ctrl_defs::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        imemReady,
  output logic        imemReq,
  output logic        irWrite,
  input  logic        validInst,
  input  logic        branch,
  input  logic [1:0]  jump,
  input  logic [1:0]  resultSel,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        regWrite,
  input  logic        branchTaken,
  output logic        dmemReq,
  output logic        dmemWe,
  input  logic        dmemReady,
  output logic        pcWrite,
  output logic [1:0]  pcSel,
  output logic        regWriteEn,
  output logic        halted,
  output logic        illegal,
  output logic        busErr,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  logic [2:0]  state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] instret_q, instret_d;
  logic        waiting;
  logic        expired;

  assign imemReq  = (state_q == S_FETCH);
  assign dmemReq  = (state_q == S_MEM);
  assign waiting  = imemReq | dmemReq;

  // FETCH and MEM are never adjacent, so clearing outside them clears on entry.
  mem_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .ready  (imemReq ? imemReady : dmemReady),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imemReady) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (!validInst || (memRead && memWrite)) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (memRead || memWrite) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmemReady) begin
          state_d = S_WB;
        end else if (expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        instret_d = instret_q + 32'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign irWrite    = imemReq & imemReady;
  assign dmemWe     = dmemReq & memWrite;
  assign pcWrite    = (state_q == S_WB);
  assign regWriteEn = pcWrite & regWrite;
  assign pcSel      = pcWrite ? pc_select(branch, jump, resultSel, branchTaken) : PCSEL_SEQ;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign busErr     = bus_err_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, randomized instruction
// stream against a trace model, and hand-written trap/reset/timeout sequences.
module tb_multicycle_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst, run, imemReady, imemReq, irWrite, validInst, branch;
  logic [1:0]  jump, resultSel, pcSel;
  logic        memRead, memWrite, regWrite, branchTaken;
  logic        dmemReq, dmemWe, dmemReady, pcWrite, regWriteEn;
  logic        halted, illegal, busErr;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .imemReady(imemReady), .imemReq(imemReq),
    .irWrite(irWrite), .validInst(validInst), .branch(branch), .jump(jump),
    .resultSel(resultSel), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .branchTaken(branchTaken), .dmemReq(dmemReq),
    .dmemWe(dmemWe), .dmemReady(dmemReady), .pcWrite(pcWrite), .pcSel(pcSel),
    .regWriteEn(regWriteEn), .halted(halted), .illegal(illegal), .busErr(busErr),
    .state(state), .instret(instret)
  );

  typedef struct {
    logic vi, br; logic [1:0] jmp, rsel; logic mr, mw, rw, tk; int di, dd;
  } instr_t;
  typedef struct packed { logic imr; logic dmr; logic [13:0] o; } cyc_t;
  typedef struct {
    instr_t i; logic [1:0] pc; logic rwe; int memc, totc, wec;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_instret;
  cyc_t        exp_q[$];
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  function automatic logic [13:0] obs();
    return {state, imemReq, irWrite, dmemReq, dmemWe, pcWrite, regWriteEn,
            pcSel, halted, illegal, busErr};
  endfunction

  function automatic logic [13:0] mk(input logic [2:0] st, input logic imreq, input logic irw,
                                     input logic dmreq, input logic dmwe, input logic pcw,
                                     input logic rwe, input logic [1:0] pcs, input logic hlt,
                                     input logic ill, input logic be);
    return {st, imreq, irw, dmreq, dmwe, pcw, rwe, pcs, hlt, ill, be};
  endfunction

  function automatic cyc_t cyc(input logic imr, input logic dmr, input logic [13:0] o);
    cyc_t c;
    c.imr = imr; c.dmr = dmr; c.o = o;
    return c;
  endfunction

  function automatic instr_t mi(input logic br, input logic [1:0] jmp, input logic [1:0] rsel,
                                input logic mr, input logic mw, input logic rw,
                                input logic tk, input int di, input int dd);
    instr_t i;
    i.vi = 1'b1; i.br = br; i.jmp = jmp; i.rsel = rsel; i.mr = mr; i.mw = mw;
    i.rw = rw; i.tk = tk; i.di = di; i.dd = dd;
    return i;
  endfunction

  function automatic logic [1:0] ref_pcsel(input instr_t i);
    if (i.jmp == 2'b11) return 2'b10;
    if (i.rsel == 2'b10) return 2'b01;
    if (i.br && i.tk) return 2'b01;
    return 2'b00;
  endfunction

  // Expected cycle-by-cycle trace of one legal instruction, starting in FETCH.
  function automatic void build(input instr_t i);
    exp_q.delete();
    for (int k = 0; k <= i.di; k++)
      exp_q.push_back(cyc(k == i.di, 1'b0, mk(3'd1, 1, k == i.di, 0, 0, 0, 0, 2'b00, 0, 0, 0)));
    exp_q.push_back(cyc(1'b0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)));
    exp_q.push_back(cyc(1'b0, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)));
    if (i.mr || i.mw)
      for (int k = 0; k <= i.dd; k++)
        exp_q.push_back(cyc(1'b0, k == i.dd, mk(3'd4, 0, 0, 1, i.mw, 0, 0, 2'b00, 0, 0, 0)));
    exp_q.push_back(cyc(1'b0, 1'b0, mk(3'd5, 0, 0, 0, 0, 1, i.rw, ref_pcsel(i), 0, 0, 0)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imemReady = 1'b0; dmemReady = 1'b0; validInst = 1'b1;
    branch = 1'b0; jump = 2'b00; resultSel = 2'b00; memRead = 1'b0; memWrite = 1'b0;
    regWrite = 1'b0; branchTaken = 1'b0;
    step();
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic go();
    run = 1'b1;
    #1;
    chk("idle before start", 32'(state), 32'd0);
    step();
  endtask

  task automatic run_instr(input instr_t i, input bit noise, input bit drop_run,
                           output logic [1:0] wpc, output logic wrwe,
                           output int memc, output int totc, output int wec);
    logic [2:0] st;
    cyc_t e;
    build(i);
    wpc = 2'b00; wrwe = 1'b0; memc = 0; totc = 0; wec = 0;
    validInst = i.vi; branch = i.br; jump = i.jmp; resultSel = i.rsel;
    memRead = i.mr; memWrite = i.mw; regWrite = i.rw; branchTaken = i.tk;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      st = e.o[13:11];
      imemReady = e.imr;
      dmemReady = e.dmr;
      if (noise && st != 3'd1) imemReady = 1'($urandom_range(0, 1));
      if (noise && st != 3'd4) dmemReady = 1'($urandom_range(0, 1));
      if (drop_run && st == 3'd4) run = 1'b0;
      #1;
      chk($sformatf("cycle %0d state %0d outputs", k, st), 32'(obs()), 32'(e.o));
      if (state == 3'd5) begin wpc = pcSel; wrwe = regWriteEn; end
      if (dmemReq) memc++;
      if (dmemWe) wec++;
      totc++;
      step();
    end
    imemReady = 1'b0;
    dmemReady = 1'b0;
    exp_instret = exp_instret + 32'd1;
    chk("instret after retire", instret, exp_instret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] wpc;
    logic       wrwe;
    int         mc, tc, wc;
    instr_t     ri;

    //                  br  jmp    rsel   mr mw rw tk di dd     pc     rwe memc totc wec
    tbl[0] = '{mi(0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0), 2'b00, 1'b1, 0, 4, 0};
    tbl[1] = '{mi(0, 2'b00, 2'b01, 1, 0, 1, 0, 1, 3), 2'b00, 1'b1, 4, 9, 0};
    tbl[2] = '{mi(0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1), 2'b00, 1'b0, 2, 6, 2};
    tbl[3] = '{mi(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0), 2'b01, 1'b0, 0, 4, 0};
    tbl[4] = '{mi(1, 2'b00, 2'b00, 0, 0, 0, 0, 2, 0), 2'b00, 1'b0, 0, 6, 0};
    tbl[5] = '{mi(0, 2'b11, 2'b10, 0, 0, 1, 0, 0, 0), 2'b10, 1'b1, 0, 4, 0};
    tbl[6] = '{mi(0, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0), 2'b01, 1'b1, 0, 4, 0};

    // Reset state and IDLE hold.
    do_reset();
    chk("reset outputs", 32'(obs()), 32'd0);
    chk("reset instret", instret, 32'd0);
    step(); step();
    chk("idle holds without run", 32'(state), 32'd0);

    // Directed vector table, back to back.
    go();
    for (int v = 0; v < 7; v++) begin
      run_instr(tbl[v].i, 1'b0, 1'b0, wpc, wrwe, mc, tc, wc);
      chk($sformatf("vec%0d pcSel", v), 32'(wpc), 32'(tbl[v].pc));
      chk($sformatf("vec%0d regWriteEn", v), 32'(wrwe), 32'(tbl[v].rwe));
      chk($sformatf("vec%0d mem cycles", v), 32'(mc), 32'(tbl[v].memc));
      chk($sformatf("vec%0d total cycles", v), 32'(tc), 32'(tbl[v].totc));
      chk($sformatf("vec%0d dmemWe cycles", v), 32'(wc), 32'(tbl[v].wec));
    end

    // Randomized instruction stream with ready noise outside the waiting states.
    do_reset();
    go();
    for (int n = 0; n < 40; n++) begin
      ri = mi(0, 2'b00, 2'b00, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, T - 1), $urandom_range(0, T - 1));
      case ($urandom_range(0, 5))
        0: ri.rsel = 2'($urandom_range(0, 1));
        1: ri.mr = 1'b1;
        2: ri.mw = 1'b1;
        3: ri.br = 1'b1;
        4: ri.rsel = 2'b10;
        default: begin ri.jmp = 2'b11; ri.rsel = 2'b10; end
      endcase
      run_instr(ri, 1'b1, 1'b0, wpc, wrwe, mc, tc, wc);
    end

    // Fetch timeout: four FETCH cycles without ready.
    do_reset();
    go();
    for (int k = 0; k < T; k++) begin
      chk($sformatf("timeout fetch cycle %0d", k), 32'(obs()),
          32'(mk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)));
      step();
    end
    chk("fetch timeout halt", 32'(obs()), 32'(mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1)));
    chk("fetch timeout instret", instret, 32'd0);

    // Ready in the last allowed cycle wins.
    do_reset();
    go();
    for (int k = 0; k < T - 1; k++) step();
    imemReady = 1'b1;
    #1;
    chk("late ready irWrite", 32'(irWrite), 32'd1);
    step();
    imemReady = 1'b0;
    chk("late ready decode", 32'(obs()), 32'(mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0)));

    // Data-side timeout.
    do_reset();
    memRead = 1'b1;
    regWrite = 1'b1;
    go();
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    step(); step();
    for (int k = 0; k < T; k++) begin
      chk($sformatf("mem timeout cycle %0d", k), 32'(obs()),
          32'(mk(3'd4, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0)));
      step();
    end
    chk("mem timeout halt", 32'(obs()), 32'(mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1)));

    // Illegal instruction, ignored fetch readies, then reset.
    do_reset();
    go();
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    validInst = 1'b0;
    chk("illegal in decode", 32'(state), 32'd2);
    step();
    validInst = 1'b1;
    chk("illegal halt", 32'(obs()), 32'(mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0)));
    for (int k = 0; k < 3; k++) begin
      imemReady = 1'b1;
      dmemReady = 1'b1;
      #1;
      chk($sformatf("halt ignores ready %0d", k), 32'(obs()),
          32'(mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0)));
      step();
    end
    chk("halt instret", instret, 32'd0);
    do_reset();
    chk("reset after halt", 32'(obs()), 32'd0);

    // memRead together with memWrite is illegal.
    go();
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    memRead = 1'b1;
    memWrite = 1'b1;
    step();
    chk("rd+wr illegal", 32'(obs()), 32'(mk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0)));

    // instret wrap.
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFF;
    step(); step();
    release dut.instret_q;
    #1;
    chk("instret preload", instret, 32'hFFFF_FFFF);
    exp_instret = 32'hFFFF_FFFF;
    go();
    run_instr(tbl[0].i, 1'b0, 1'b0, wpc, wrwe, mc, tc, wc);

    // run dropped mid-MEM: instruction completes, then IDLE.
    do_reset();
    go();
    run_instr(mi(0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 2), 1'b0, 1'b1, wpc, wrwe, mc, tc, wc);
    chk("run drop retire regWriteEn", 32'(wrwe), 32'd1);
    chk("run drop idle", 32'(obs()), 32'd0);
    step();
    chk("run drop stays idle", 32'(state), 32'd0);

    // Reset mid-MEM drops the request.
    do_reset();
    memRead = 1'b1;
    go();
    imemReady = 1'b1;
    step();
    imemReady = 1'b0;
    step(); step();
    chk("mid-mem request", 32'(dmemReq), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset mid-mem outputs", 32'(obs()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
